// File: rtl/uart_arb_pkg.sv
// Shared definitions for the round-robin UART transmit arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_e;

  localparam int DEF_BUSY_TIMEOUT = 64;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index at or after rr_ptr, wrapping upward.
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic                       any_valid,
  output logic [$clog2(NUM_REQ)-1:0] win
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int SW  = IDW + 1;

  always_comb begin
    logic [SW-1:0] idx;
    logic          found;
    any_valid = |req_valid;
    win       = '0;
    found     = 1'b0;
    idx       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, rr_ptr} + SW'(i);
      idx = (idx >= SW'(NUM_REQ)) ? (idx - SW'(NUM_REQ)) : idx;
      if (!found && req_valid[idx[IDW-1:0]]) begin
        win   = idx[IDW-1:0];
        found = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters,
// with single-cycle enable, held payload, completion pulses and a busy-rise watchdog.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic [NUM_REQ-1:0]            req_done,
  output logic                          uart_enable,
  output logic [DATA_WIDTH-1:0]         uart_data,
  input  logic                          uart_busy,
  output logic [$clog2(NUM_REQ)-1:0]    active_id,
  output logic                          arb_busy,
  output logic                          timeout_err
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int WDW = $clog2(BUSY_TIMEOUT);
  localparam logic [WDW-1:0]     WD_LAST  = WDW'(BUSY_TIMEOUT - 1);
  localparam logic [IDW-1:0]     LAST_ID  = IDW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  arb_state_e            state_q, state_d;
  logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [WDW-1:0]        wd_q, wd_d;
  logic [DATA_WIDTH-1:0] uart_data_q, uart_data_d;
  logic [IDW-1:0]        active_id_q, active_id_d;
  logic [NUM_REQ-1:0]    req_ack_q, req_ack_d;
  logic [NUM_REQ-1:0]    req_done_q, req_done_d;
  logic                  uart_enable_q, uart_enable_d;
  logic                  arb_busy_q, arb_busy_d;
  logic                  timeout_err_q, timeout_err_d;

  logic                  any_valid_s;
  logic [IDW-1:0]        win_s;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .any_valid (any_valid_s),
    .win       (win_s)
  );

  // Next-state and registered-output logic; ack/enable/done/timeout are one-cycle pulses.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    wd_d          = wd_q;
    uart_data_d   = uart_data_q;
    active_id_d   = active_id_q;
    req_ack_d     = '0;
    req_done_d    = '0;
    uart_enable_d = 1'b0;
    timeout_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_valid_s && !uart_busy) begin
          state_d       = ISSUE;
          uart_data_d   = req_data[int'(win_s)*DATA_WIDTH +: DATA_WIDTH];
          active_id_d   = win_s;
          rr_ptr_d      = (win_s == LAST_ID) ? '0 : (win_s + IDW'(1));
          req_ack_d     = ONE_HOT0 << win_s;
          uart_enable_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        wd_d    = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (uart_busy) begin
          state_d = WAIT_DONE;
        end else if (wd_q == WD_LAST) begin
          state_d       = IDLE;
          timeout_err_d = 1'b1;
          active_id_d   = '0;
        end else begin
          wd_d = (wd_q == '1) ? wd_q : (wd_q + WDW'(1));
        end
      end
      WAIT_DONE: begin
        if (!uart_busy) begin
          req_done_d  = ONE_HOT0 << active_id_q;
          active_id_d = '0;
          state_d     = IDLE;
        end else begin
          state_d = WAIT_DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    arb_busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      wd_q          <= '0;
      uart_data_q   <= '0;
      active_id_q   <= '0;
      req_ack_q     <= '0;
      req_done_q    <= '0;
      uart_enable_q <= 1'b0;
      arb_busy_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      wd_q          <= wd_d;
      uart_data_q   <= uart_data_d;
      active_id_q   <= active_id_d;
      req_ack_q     <= req_ack_d;
      req_done_q    <= req_done_d;
      uart_enable_q <= uart_enable_d;
      arb_busy_q    <= arb_busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign req_ack     = req_ack_q;
  assign req_done    = req_done_q;
  assign uart_enable = uart_enable_q;
  assign uart_data   = uart_data_q;
  assign active_id   = active_id_q;
  assign arb_busy    = arb_busy_q;
  assign timeout_err = timeout_err_q;

endmodule
